// File: rtl/bcd20_run_ctrl.sv
// bcd20_run_ctrl: sequencing controller for the 0..20 BCD counter.
// Issues CLR/LOAD/DATA/ENP/ENT, prescales the count rate and stops on a
// programmable terminal value with a one-cycle DONE pulse.
// Build option: define BCD20_AUTO_RELOAD_EN to restart from zero on reaching
// the target (periodic mode) instead of stopping in HOLD.
`timescale 1ns/1ps

module bcd20_run_ctrl #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned PS_W     = 8
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       START,
  input  logic       STOP,
  input  logic       PRESET,
  input  logic [3:0] PRESET_VAL,
  input  logic [4:0] TARGET,
  input  logic [7:0] CNT_Q,
  output logic       CNT_LOAD,
  output logic       CNT_CLR,
  output logic [3:0] CNT_DATA,
  output logic       CNT_ENP,
  output logic       CNT_ENT,
  output logic       BUSY,
  output logic       DONE,
  output logic [2:0] STATE
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TGT_W   = 5;
  localparam int unsigned DATA_W  = 4;
  localparam logic [TGT_W-1:0] TGT_MAX = TGT_W'(20);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_HOLD  = 3'd4,
    S_LOAD  = 3'd5,
    S_CLEAR = 3'd6
  } state_e;

`ifdef BCD20_AUTO_RELOAD_EN
  localparam state_e S_AT_TARGET = S_CLEAR;
`else
  localparam state_e S_AT_TARGET = S_HOLD;
`endif

  state_e              state_q, state_d;
  logic [PS_W-1:0]     ps_q, ps_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                clr_q, clr_d;
  logic                load_q, load_d;
  logic                busy_q, busy_d;

  logic [TGT_W-1:0]    tgt_eff;
  logic                at_target;
  logic                tick;
  logic                start_cmd;

  // Clamp the terminal value and flag the prescaler wrap point.
  always_comb begin
    tgt_eff   = (TARGET > TGT_MAX) ? TGT_MAX : TARGET;
    at_target = (CNT_Q == CNT_W'(tgt_eff));
    tick      = (ps_q == PS_LAST);
    start_cmd = START & ~STOP;
  end

  // Count enables track the live counter value, so they stay combinational.
  assign CNT_ENP = (state_q == S_RUN) & tick & ~at_target;
  assign CNT_ENT = CNT_ENP;

  // Next-state, prescaler and registered-output decode.
  always_comb begin
    state_d = state_q;
    ps_d    = ps_q;
    data_d  = data_q;
    done_d  = 1'b0;

    if ((state_q != S_INIT) && PRESET) begin
      state_d = S_LOAD;
      data_d  = PRESET_VAL;
    end else begin
      unique case (state_q)
        S_INIT:  state_d = S_IDLE;
        S_IDLE:  if (start_cmd) state_d = S_RUN;
        S_RUN: begin
          if (STOP) begin
            state_d = S_PAUSE;
          end else if (at_target) begin
            state_d = S_AT_TARGET;
            done_d  = 1'b1;
          end
        end
        S_PAUSE: if (start_cmd) state_d = S_RUN;
        S_HOLD:  if (start_cmd) state_d = S_CLEAR;
        S_LOAD:  state_d = S_IDLE;
        S_CLEAR: state_d = S_RUN;
        default: state_d = S_INIT;
      endcase
    end

    // Prescaler runs only in RUN and restarts on every entry into RUN.
    if (state_q == S_RUN) begin
      ps_d = tick ? '0 : ps_q + 1'b1;
    end
    if ((state_d == S_RUN) && (state_q != S_RUN)) begin
      ps_d = '0;
    end

    clr_d  = (state_d == S_INIT) || (state_d == S_CLEAR);
    load_d = (state_d == S_LOAD);
`ifdef BCD20_AUTO_RELOAD_EN
    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE) || (state_d == S_CLEAR);
`else
    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
`endif
  end

  // State and output registers; reset clears the counter via CNT_CLR.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= S_INIT;
      ps_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      clr_q   <= 1'b1;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      data_q  <= data_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
    end
  end

  assign CNT_CLR  = clr_q;
  assign CNT_LOAD = load_q;
  assign CNT_DATA = data_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_bcd20_run_ctrl.sv
// Bench for bcd20_run_ctrl: a behavioural counter fixture closes the loop,
// a cycle-level reference model is compared every cycle, and directed
// scenarios check timing derived from the prescale arithmetic.
`timescale 1ns/1ps

module tb_bcd20_run_ctrl;

  localparam int PRESCALE = 4;
  localparam int S_INIT = 0, S_IDLE = 1, S_RUN = 2, S_PAUSE = 3;
  localparam int S_HOLD = 4, S_LOAD = 5, S_CLEAR = 6;
`ifdef BCD20_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       CLR_N = 1'b1;
  logic       START = 1'b0, STOP = 1'b0, PRESET = 1'b0;
  logic [3:0] PRESET_VAL = 4'd0;
  logic [4:0] TARGET = 5'd20;
  logic [7:0] CNT_Q;
  logic       CNT_LOAD, CNT_CLR, CNT_ENP, CNT_ENT, BUSY, DONE;
  logic [3:0] CNT_DATA;
  logic [2:0] STATE;

  int n_cmp = 0, n_bad = 0;
  int en_seen = 0, done_seen = 0;

  // Reference model: current mode, cycles since RUN entry (mod PRESCALE), data, done.
  int m_st = S_INIT, m_ps = 0, m_data = 0;
  bit m_done = 1'b0;
  int n_st, n_ps, n_data;
  bit n_done;

  logic [7:0] cnt = 8'd13;

  bcd20_run_ctrl #(.PRESCALE(4), .PS_W(8)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .START(START), .STOP(STOP), .PRESET(PRESET),
    .PRESET_VAL(PRESET_VAL), .TARGET(TARGET), .CNT_Q(CNT_Q),
    .CNT_LOAD(CNT_LOAD), .CNT_CLR(CNT_CLR), .CNT_DATA(CNT_DATA),
    .CNT_ENP(CNT_ENP), .CNT_ENT(CNT_ENT), .BUSY(BUSY), .DONE(DONE), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  // Counter fixture: CLR over LOAD over count, wraps 20 -> 0.
  assign CNT_Q = cnt;
  always @(posedge CLK) begin
    if (CNT_CLR) cnt <= 8'd0;
    else if (CNT_LOAD) cnt <= {4'd0, CNT_DATA};
    else if (CNT_ENP && CNT_ENT) cnt <= (cnt >= 8'd20) ? 8'd0 : cnt + 8'd1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int teff();
    return (int'(TARGET) > 20) ? 20 : int'(TARGET);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit en, busy;
    en   = (m_st == S_RUN) && (m_ps == PRESCALE - 1) && (int'(cnt) != teff());
    busy = (m_st == S_RUN) || (m_st == S_PAUSE) || (AUTO && m_st == S_CLEAR);
    chk("state", 32'(STATE), 32'(m_st));
    chk("clr",   32'(CNT_CLR), 32'(m_st == S_INIT || m_st == S_CLEAR));
    chk("load",  32'(CNT_LOAD), 32'(m_st == S_LOAD));
    chk("data",  32'(CNT_DATA), 32'(m_data));
    chk("enp",   32'(CNT_ENP), 32'(en));
    chk("ent",   32'(CNT_ENT), 32'(en));
    chk("busy",  32'(BUSY), 32'(busy));
    chk("done",  32'(DONE), 32'(m_done));
  endtask

  task automatic model_next();
    bit hit, go;
    n_st = m_st; n_ps = m_ps; n_data = m_data; n_done = 1'b0;
    if (!CLR_N) begin
      n_st = S_INIT; n_ps = 0; n_data = 0;
      return;
    end
    hit = (int'(cnt) == teff());
    go  = START && !STOP;
    if (m_st == S_INIT) n_st = S_IDLE;
    else if (PRESET) begin
      n_st = S_LOAD; n_data = int'(PRESET_VAL);
    end else if (m_st == S_IDLE && go) n_st = S_RUN;
    else if (m_st == S_PAUSE && go) n_st = S_RUN;
    else if (m_st == S_HOLD && go) n_st = S_CLEAR;
    else if (m_st == S_LOAD) n_st = S_IDLE;
    else if (m_st == S_CLEAR) n_st = S_RUN;
    else if (m_st == S_RUN && STOP) n_st = S_PAUSE;
    else if (m_st == S_RUN && hit) begin
      n_st = AUTO ? S_CLEAR : S_HOLD; n_done = 1'b1;
    end
    if (m_st == S_RUN) n_ps = (m_ps + 1) % PRESCALE;
    if (n_st == S_RUN && m_st != S_RUN) n_ps = 0;
  endtask

  // One clock: check at the falling edge, advance model with the rising edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      check_outputs();
      if (CNT_ENP) en_seen++;
      if (DONE) done_seen++;
      model_next();
      @(posedge CLK);
      m_st = n_st; m_ps = n_ps; m_data = n_data; m_done = n_done;
      @(negedge CLK);
    end
  endtask

  task automatic pulse(input logic s, input logic p, input logic pr, input logic [3:0] pv);
    START = s; STOP = p; PRESET = pr; PRESET_VAL = pv;
    cyc(1);
    START = 1'b0; STOP = 1'b0; PRESET = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int waited);
    waited = 0;
    while (!DONE && waited < budget) begin
      cyc(1);
      waited++;
    end
    chk("done_reached", 32'(DONE), 32'd1);
  endtask

  task automatic wait_cnt(input int v, input bit need_en, input int budget);
    int w;
    w = 0;
    while (!(int'(cnt) == v && (!need_en || CNT_ENP)) && w < budget) begin
      cyc(1);
      w++;
    end
    chk("cnt_reached", 32'(cnt), 32'(v));
  endtask

  initial begin
    int w, e0, r;
    CLR_N = 1'b0;
    @(negedge CLK);
    cyc(3);
    chk("rst_state", 32'(STATE), 32'(S_INIT));
    chk("rst_clr", 32'(CNT_CLR), 32'd1);
    CLR_N = 1'b1;
    cyc(1);
    chk("idle_after_init", 32'(STATE), 32'(S_IDLE));
    chk("cnt_cleared", 32'(cnt), 32'd0);

`ifndef BCD20_AUTO_RELOAD_EN
    // Full count 0..20.
    TARGET = 5'd20; en_seen = 0; done_seen = 0;
    pulse(1, 0, 0, 4'd0);
    wait_done(400, w);
    chk("t1_wait", 32'(w), 32'(PRESCALE * 20 + 1));
    chk("t1_enables", 32'(en_seen), 32'd20);
    chk("t1_cnt", 32'(cnt), 32'd20);
    chk("t1_hold", 32'(STATE), 32'(S_HOLD));
    cyc(1);
    e0 = en_seen;
    cyc(50);
    chk("t1_no_en", 32'(en_seen - e0), 32'd0);
    chk("t1_done_once", 32'(done_seen), 32'd1);

    // Pause at 7, resume.
    pulse(1, 0, 0, 4'd0);
    wait_cnt(7, 1'b0, 200);
    pulse(0, 1, 0, 4'd0);
    chk("t2_pause", 32'(STATE), 32'(S_PAUSE));
    e0 = en_seen;
    cyc(40);
    chk("t2_no_en", 32'(en_seen - e0), 32'd0);
    chk("t2_cnt_held", 32'(cnt), 32'd7);
    en_seen = 0;
    pulse(1, 0, 0, 4'd0);
    wait_done(200, w);
    chk("t2_wait", 32'(w), 32'(PRESCALE * 13 + 1));
    chk("t2_enables", 32'(en_seen), 32'd13);

    // Preset during RUN.
    pulse(1, 0, 0, 4'd0);
    cyc(10);
    pulse(0, 0, 1, 4'd5);
    chk("t3_load", 32'(CNT_LOAD), 32'd1);
    chk("t3_data", 32'(CNT_DATA), 32'd5);
    cyc(1);
    chk("t3_idle", 32'(STATE), 32'(S_IDLE));
    chk("t3_busy", 32'(BUSY), 32'd0);
    chk("t3_cnt", 32'(cnt), 32'd5);
    en_seen = 0;
    pulse(1, 0, 0, 4'd0);
    wait_done(200, w);
    chk("t3_wait", 32'(w), 32'(PRESCALE * 15 + 1));
    chk("t3_enables", 32'(en_seen), 32'd15);

    // Priority, clamp and zero target.
    pulse(1, 1, 1, 4'd3);
    chk("t4_prio", 32'(STATE), 32'(S_LOAD));
    cyc(1);
    TARGET = 5'd25; en_seen = 0;
    pulse(1, 0, 0, 4'd0);
    wait_done(200, w);
    chk("t4_clamp_wait", 32'(w), 32'(PRESCALE * 17 + 1));
    chk("t4_clamp_cnt", 32'(cnt), 32'd20);
    pulse(0, 0, 1, 4'd0);
    cyc(1);
    TARGET = 5'd0; en_seen = 0;
    pulse(1, 0, 0, 4'd0);
    wait_done(10, w);
    chk("t4_zero_wait", 32'(w), 32'd1);
    chk("t4_zero_en", 32'(en_seen), 32'd0);

    // Asynchronous reset with an enable pending at 9.
    TARGET = 5'd20;
    pulse(0, 0, 1, 4'd0);
    cyc(1);
    pulse(1, 0, 0, 4'd0);
    wait_cnt(9, 1'b1, 200);
    check_outputs();
    #2 CLR_N = 1'b0;
    #1;
    chk("t5_enp_async", 32'(CNT_ENP), 32'd0);
    chk("t5_state_async", 32'(STATE), 32'(S_INIT));
    chk("t5_clr_async", 32'(CNT_CLR), 32'd1);
    m_st = S_INIT; m_ps = 0; m_data = 0; m_done = 1'b0;
    @(negedge CLK);
    cyc(2);
    CLR_N = 1'b1;
    chk("t5_init", 32'(STATE), 32'(S_INIT));
    cyc(1);
    chk("t5_idle", 32'(STATE), 32'(S_IDLE));
    chk("t5_cnt", 32'(cnt), 32'd0);
`else
    // Periodic mode with target 3.
    TARGET = 5'd3; done_seen = 0;
    pulse(1, 0, 0, 4'd0);
    wait_done(100, w);
    chk("t6_first", 32'(w), 32'(PRESCALE * 3 + 1));
    chk("t6_cnt_top", 32'(cnt), 32'd3);
    cyc(1);
    chk("t6_cnt_wrap", 32'(cnt), 32'd0);
    wait_done(100, w);
    chk("t6_period", 32'(w + 1), 32'(PRESCALE * 3 + 2));
    chk("t6_busy", 32'(BUSY), 32'd1);
    cyc(1);
    wait_done(100, w);
    chk("t6_period2", 32'(w + 1), 32'(PRESCALE * 3 + 2));
`endif

    // Random command traffic against the model.
    for (int k = 0; k < 800; k++) begin
      r = int'($urandom_range(0, 99));
      START  = (r < 6) || (r == 99);
      STOP   = (r >= 6 && r < 9) || (r == 99);
      PRESET = (r >= 9 && r < 11) || (r == 99);
      PRESET_VAL = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 49) == 0) TARGET = 5'($urandom_range(0, 31));
      cyc(1);
    end
    START = 1'b0; STOP = 1'b0; PRESET = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
